// File: rtl/mem_stage_pkg.sv
// Shared widths, rf-write bundle layout and load-op bit positions for the MEM stage.
package mem_stage_pkg;

  localparam int M_RFC_WID    = 38;  // {rf_we, rf_waddr[4:0], data[31:0]}
  localparam int M2W_WID      = 26;  // {except[15:0], s1_found, s1_index[3:0], tlb ops[4:0]}
  localparam int D2C_CSRC_WID = 79;  // CSR bundle, carried through untouched
  localparam int EXC_WID      = 16;  // except field sits in the top bits of the M2W bus

  // One-hot load-op vector {ld_w, ld_hu, ld_h, ld_bu, ld_b}
  localparam int LD_OP_WID = 5;
  localparam int LD_B      = 0;
  localparam int LD_BU     = 1;
  localparam int LD_H      = 2;
  localparam int LD_HU     = 3;
  localparam int LD_W      = 4;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } rf_collect_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Selects and extends the addressed byte/half/word of a load response.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [LD_OP_WID-1:0] mem_op,
  input  logic [1:0]           offset,
  input  logic [31:0]          raw,
  output logic [31:0]          wdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the lane, then extend according to the one-hot load op.
  always_comb begin
    case (offset)
      2'd0:    byte_sel = raw[7:0];
      2'd1:    byte_sel = raw[15:8];
      2'd2:    byte_sel = raw[23:16];
      default: byte_sel = raw[31:24];
    endcase
    // Halfword loads are always halfword aligned, so only offset[1] matters.
    half_sel = offset[1] ? raw[31:16] : raw[15:0];

    wdata = raw;
    if (mem_op[LD_B])       wdata = {{24{byte_sel[7]}}, byte_sel};
    else if (mem_op[LD_BU]) wdata = {24'h0, byte_sel};
    else if (mem_op[LD_H])  wdata = {{16{half_sel[15]}}, half_sel};
    else if (mem_op[LD_HU]) wdata = {16'h0, half_sel};
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, waits for the data-SRAM response,
// aligns load data, forwards everything to WB and bypass/stall info to ID.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int CSRC_W = D2C_CSRC_WID,
  parameter int M2W_W  = M2W_WID
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 es_to_ms_valid,
  output logic                 ms_allowin,
  input  logic [31:0]          es_pc,
  input  logic [M_RFC_WID-1:0] es_rf_collect,
  input  logic [LD_OP_WID-1:0] es_mem_op,
  input  logic                 es_mem_req,
  input  logic [M2W_W-1:0]     es_to_ms_bus,
  input  logic [31:0]          es_vaddr,
  input  logic [CSRC_W-1:0]    es_csr_collect,
  input  logic                 data_sram_data_ok,
  input  logic [31:0]          data_sram_rdata,
  input  logic                 ws_allowin,
  input  logic                 wb_flush,
  output logic                 ms_to_ws_valid,
  output logic [31:0]          ms_pc,
  output logic [M_RFC_WID-1:0] ms_rf_collect,
  output logic [M2W_W-1:0]     ms_to_ws_bus,
  output logic [31:0]          vaddr,
  output logic [CSRC_W-1:0]    ms_to_ws_csr_collect,
  output logic [M_RFC_WID-1:0] ms_fwd,
  output logic                 ms_load_stall,
  output logic                 ms_ex
);

  logic                 ms_valid_q,   ms_valid_d;
  logic [31:0]          pc_q,         pc_d;
  rf_collect_t          rfc_q,        rfc_d;
  logic [LD_OP_WID-1:0] mem_op_q,     mem_op_d;
  logic                 mem_req_q,    mem_req_d;
  logic [M2W_W-1:0]     bus_q,        bus_d;
  logic [31:0]          vaddr_q,      vaddr_d;
  logic [CSRC_W-1:0]    csr_q,        csr_d;
  logic [31:0]          resp_buf_q,   resp_buf_d;
  logic                 resp_buf_v_q, resp_buf_v_d;
  logic [1:0]           drop_cnt_q,   drop_cnt_d;

  logic        except_any, ertn, wait_resp, resp_now, ms_ready_go;
  logic        capture, handoff, flush_orphan, flush_ex_req, drop_dec;
  logic [1:0]  drop_inc;
  logic [2:0]  drop_sum;
  logic [31:0] raw_data, load_wdata, final_wdata;

  // Handshake: an excepting instruction never waits, even if a request was sent.
  always_comb begin
    except_any     = |bus_q[M2W_W-1 -: EXC_WID];
    ertn           = csr_q[CSRC_W-1];  // ertn flag is the MSB of the CSR bundle
    wait_resp      = mem_req_q & ~except_any;
    resp_now       = data_sram_data_ok & (drop_cnt_q == 2'd0);
    ms_ready_go    = ~wait_resp | resp_now | resp_buf_v_q;
    ms_allowin     = ~ms_valid_q | (ms_ready_go & ws_allowin);
    ms_to_ws_valid = ms_valid_q & ms_ready_go & ~wb_flush;
    capture        = es_to_ms_valid & ms_allowin;
    handoff        = ms_to_ws_valid & ws_allowin;
    raw_data       = resp_buf_v_q ? resp_buf_q : data_sram_rdata;
  end

  load_align u_load_align (
    .mem_op (mem_op_q),
    .offset (vaddr_q[1:0]),
    .raw    (raw_data),
    .wdata  (load_wdata)
  );

  // Output bundles; non-load instructions carry the ALU result straight through.
  always_comb begin
    final_wdata          = (|mem_op_q) ? load_wdata : rfc_q.wdata;
    ms_pc                = pc_q;
    ms_rf_collect        = {rfc_q.we, rfc_q.waddr, final_wdata};
    ms_to_ws_bus         = bus_q;
    vaddr                = vaddr_q;
    ms_to_ws_csr_collect = csr_q;
    ms_fwd               = {ms_valid_q & rfc_q.we, rfc_q.waddr, final_wdata};
    ms_load_stall        = ms_valid_q & (|mem_op_q) & ~ms_ready_go;
    ms_ex                = ms_valid_q & (except_any | ertn);
  end

  // Next-state: instruction capture, response buffering and stale-response accounting.
  always_comb begin
    pc_d      = capture ? es_pc          : pc_q;
    rfc_d     = capture ? es_rf_collect  : rfc_q;
    mem_op_d  = capture ? es_mem_op      : mem_op_q;
    mem_req_d = capture ? es_mem_req     : mem_req_q;
    bus_d     = capture ? es_to_ms_bus   : bus_q;
    vaddr_d   = capture ? es_vaddr       : vaddr_q;
    csr_d     = capture ? es_csr_collect : csr_q;

    ms_valid_d = ms_valid_q;
    if (wb_flush)     ms_valid_d = 1'b0;
    else if (capture) ms_valid_d = 1'b1;
    else if (ms_allowin) ms_valid_d = 1'b0;

    // Hold a response that arrives while WB is stalled; data_sram_rdata may move on.
    resp_buf_d   = resp_buf_q;
    resp_buf_v_d = resp_buf_v_q;
    if (ms_valid_q & wait_resp & resp_now & ~resp_buf_v_q & ~ws_allowin & ~wb_flush) begin
      resp_buf_d   = data_sram_rdata;
      resp_buf_v_d = 1'b1;
    end
    if (handoff | wb_flush | capture) resp_buf_v_d = 1'b0;

    // Every request orphaned by a flush leaves one response in flight to swallow.
    flush_orphan = wb_flush & ms_valid_q & wait_resp & ~resp_now & ~resp_buf_v_q;
    flush_ex_req = wb_flush & es_to_ms_valid & es_mem_req;
    drop_inc     = {1'b0, flush_orphan} + {1'b0, flush_ex_req};
    drop_dec     = data_sram_data_ok & (drop_cnt_q != 2'd0);
    drop_sum     = {1'b0, drop_cnt_q} + {1'b0, drop_inc} - {2'b00, drop_dec};
    drop_cnt_d   = (drop_sum > 3'd3) ? 2'd3 : drop_sum[1:0];
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid_q   <= 1'b0;
      pc_q         <= '0;
      rfc_q        <= '0;
      mem_op_q     <= '0;
      mem_req_q    <= 1'b0;
      bus_q        <= '0;
      vaddr_q      <= '0;
      csr_q        <= '0;
      resp_buf_q   <= '0;
      resp_buf_v_q <= 1'b0;
      drop_cnt_q   <= 2'd0;
    end else begin
      ms_valid_q   <= ms_valid_d;
      pc_q         <= pc_d;
      rfc_q        <= rfc_d;
      mem_op_q     <= mem_op_d;
      mem_req_q    <= mem_req_d;
      bus_q        <= bus_d;
      vaddr_q      <= vaddr_d;
      csr_q        <= csr_d;
      resp_buf_q   <= resp_buf_d;
      resp_buf_v_q <= resp_buf_v_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

`ifndef SYNTHESIS
  // A response with nothing outstanding means the request bookkeeping is broken.
  assert property (@(posedge clk) disable iff (reset)
    !(data_sram_data_ok && drop_cnt_q == 2'd0 &&
      !(ms_valid_q && wait_resp && !resp_buf_v_q)));
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, flush/reset sequences, random traffic.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    es_to_ms_valid = 1'b0;
  logic                    ms_allowin;
  logic [31:0]             es_pc = '0;
  logic [M_RFC_WID-1:0]    es_rf_collect = '0;
  logic [LD_OP_WID-1:0]    es_mem_op = '0;
  logic                    es_mem_req = 1'b0;
  logic [M2W_WID-1:0]      es_to_ms_bus = '0;
  logic [31:0]             es_vaddr = '0;
  logic [D2C_CSRC_WID-1:0] es_csr_collect = '0;
  logic                    data_sram_data_ok = 1'b0;
  logic [31:0]             data_sram_rdata = '0;
  logic                    ws_allowin = 1'b1;
  logic                    wb_flush = 1'b0;
  logic                    ms_to_ws_valid;
  logic [31:0]             ms_pc;
  logic [M_RFC_WID-1:0]    ms_rf_collect;
  logic [M2W_WID-1:0]      ms_to_ws_bus;
  logic [31:0]             vaddr;
  logic [D2C_CSRC_WID-1:0] ms_to_ws_csr_collect;
  logic [M_RFC_WID-1:0]    ms_fwd;
  logic                    ms_load_stall;
  logic                    ms_ex;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .reset(reset), .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
    .es_pc(es_pc), .es_rf_collect(es_rf_collect), .es_mem_op(es_mem_op),
    .es_mem_req(es_mem_req), .es_to_ms_bus(es_to_ms_bus), .es_vaddr(es_vaddr),
    .es_csr_collect(es_csr_collect), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata), .ws_allowin(ws_allowin), .wb_flush(wb_flush),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc), .ms_rf_collect(ms_rf_collect),
    .ms_to_ws_bus(ms_to_ws_bus), .vaddr(vaddr), .ms_to_ws_csr_collect(ms_to_ws_csr_collect),
    .ms_fwd(ms_fwd), .ms_load_stall(ms_load_stall), .ms_ex(ms_ex)
  );

  typedef struct {
    logic [4:0]  op;
    logic [31:0] pc;
    logic [31:0] vaddr;
    logic [31:0] alu;
    logic        we;
    logic [4:0]  waddr;
    logic        req;
    logic [15:0] exc;
    int          delay;      // data_ok arrives this many cycles after capture
    int          allow;      // ws_allowin rises this many cycles after capture
    logic [31:0] rdata;
    logic [31:0] exp_wdata;
    int          exp_lat;
  } vec_t;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: pick the addressed lane with shifts/modulo and extend arithmetically.
  function automatic logic [31:0] ref_wdata(input vec_t v);
    int unsigned raw, off, b, h;
    raw = (v.req && v.exc == 16'h0) ? v.rdata : 32'h0;
    off = v.vaddr % 4;
    b   = (raw >> (8 * off)) % 256;
    h   = (raw >> (16 * (off / 2))) % 65536;
    case (v.op)
      5'b00001: return (b >= 128) ? b + 32'hFFFFFF00 : b;
      5'b00010: return b;
      5'b00100: return (h >= 32768) ? h + 32'hFFFF0000 : h;
      5'b01000: return h;
      5'b10000: return raw;
      default:  return v.alu;
    endcase
  endfunction

  function automatic int ref_lat(input vec_t v);
    int w;
    w = (v.req && v.exc == 16'h0) ? v.delay : 0;
    return (w > v.allow) ? w : v.allow;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    logic [95:0] r96;
    logic [D2C_CSRC_WID-1:0] csr;
    logic [9:0]  tlb;
    logic        wait_r, exp_ex, done, got_ex;
    int          lat, stalls, exp_stalls;
    logic [37:0] got_rfc, got_fwd;
    logic [31:0] got_pc, got_va;
    logic [25:0] got_bus;
    logic [D2C_CSRC_WID-1:0] got_csr;
    r96 = {$urandom, $urandom, $urandom};
    csr = r96[D2C_CSRC_WID-1:0];
    tlb = 10'($urandom);
    wait_r = v.req && (v.exc == 16'h0);
    exp_ex = (v.exc != 16'h0) || csr[D2C_CSRC_WID-1];
    exp_stalls = (v.op != 5'b0 && wait_r) ? v.delay : 0;
    es_pc = v.pc; es_rf_collect = {v.we, v.waddr, v.alu}; es_mem_op = v.op;
    es_mem_req = v.req; es_to_ms_bus = {v.exc, tlb}; es_vaddr = v.vaddr;
    es_csr_collect = csr; es_to_ms_valid = 1'b1; ws_allowin = 1'b1;
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
    #1 chk({tag, ".accept"}, ms_allowin, 1);
    @(posedge clk); #1;
    es_to_ms_valid = 1'b0; es_mem_req = 1'b0;
    es_pc = $urandom; es_vaddr = $urandom; es_mem_op = 5'b0;
    got_ex = ms_ex;
    done = 1'b0; lat = -1; stalls = 0;
    got_rfc = '0; got_fwd = '0; got_pc = '0; got_va = '0; got_bus = '0; got_csr = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      data_sram_data_ok = wait_r && (c == v.delay);
      data_sram_rdata = data_sram_data_ok ? v.rdata :
                        ((wait_r && c > v.delay) ? $urandom : 32'h0);
      ws_allowin = (c >= v.allow);
      #1;
      if (ms_load_stall) stalls++;
      if (ms_to_ws_valid && ws_allowin) begin
        got_rfc = ms_rf_collect; got_fwd = ms_fwd; got_pc = ms_pc; got_va = vaddr;
        got_bus = ms_to_ws_bus; got_csr = ms_to_ws_csr_collect;
        lat = c; done = 1'b1;
      end
      @(posedge clk); #1;
    end
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0; ws_allowin = 1'b1;
    if (!done) begin
      total++; bad++;
      $display("FAIL %s.timeout: got no handoff want handoff at cycle %0d", tag, v.exp_lat);
    end else begin
      chk({tag, ".wdata"}, got_rfc[31:0], v.exp_wdata);
      chk({tag, ".we_waddr"}, got_rfc[37:32], {v.we, v.waddr});
      chk({tag, ".latency"}, lat, v.exp_lat);
      chk({tag, ".stalls"}, stalls, exp_stalls);
      chk({tag, ".pc"}, got_pc, v.pc);
      chk({tag, ".vaddr"}, got_va, v.vaddr);
      chk({tag, ".bus"}, got_bus, {v.exc, tlb});
      chk({tag, ".csr"}, got_csr, csr);
      chk({tag, ".fwd"}, got_fwd, {v.we, v.waddr, v.exp_wdata});
      chk({tag, ".ex"}, got_ex, exp_ex);
    end
    $display("txn %s op=%b va=%h rdata=%h wdata=%h lat=%0d", tag, v.op, v.vaddr, v.rdata,
             got_rfc[31:0], lat);
  endtask

  // Puts an ld_w with an accepted request into MEM; returns one cycle after capture.
  task automatic capture_load(input logic [31:0] va);
    es_pc = $urandom; es_rf_collect = {1'b1, 5'd9, va}; es_mem_op = 5'b10000;
    es_mem_req = 1'b1; es_to_ms_bus = '0; es_vaddr = va; es_csr_collect = '0;
    es_to_ms_valid = 1'b1;
    @(posedge clk); #1;
    es_to_ms_valid = 1'b0; es_mem_req = 1'b0;
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{5'b00000, 32'h1C000000, 32'h0,    32'h5,        1'b1, 5'd4, 1'b0, 16'h0,   0, 0, 32'h0,        32'h5,        0};
    vecs[1]  = '{5'b00001, 32'h1C000100, 32'h1003, 32'h1003,     1'b1, 5'd5, 1'b1, 16'h0,   3, 0, 32'h80AABBCC, 32'hFFFFFF80, 3};
    vecs[2]  = '{5'b00010, 32'h1C000104, 32'h1003, 32'h1003,     1'b1, 5'd5, 1'b1, 16'h0,   3, 0, 32'h80AABBCC, 32'h00000080, 3};
    vecs[3]  = '{5'b00100, 32'h1C000108, 32'h2002, 32'h2002,     1'b1, 5'd6, 1'b1, 16'h0,   1, 0, 32'h7FFF1234, 32'h00007FFF, 1};
    vecs[4]  = '{5'b00100, 32'h1C00010C, 32'h2000, 32'h2000,     1'b1, 5'd6, 1'b1, 16'h0,   0, 0, 32'h7FFF8234, 32'hFFFF8234, 0};
    vecs[5]  = '{5'b01000, 32'h1C000110, 32'h2000, 32'h2000,     1'b1, 5'd6, 1'b1, 16'h0,   0, 0, 32'h7FFF8234, 32'h00008234, 0};
    vecs[6]  = '{5'b00001, 32'h1C000114, 32'h3001, 32'h3001,     1'b1, 5'd8, 1'b1, 16'h0,   2, 0, 32'h12347F56, 32'h0000007F, 2};
    vecs[7]  = '{5'b10000, 32'h1C000118, 32'h4000, 32'h4000,     1'b1, 5'd3, 1'b1, 16'h0,   1, 3, 32'hCAFEF00D, 32'hCAFEF00D, 3};
    vecs[8]  = '{5'b10000, 32'h1C00011C, 32'h4001, 32'h4001,     1'b1, 5'd7, 1'b0, 16'h0100, 0, 0, 32'h0,       32'h0,        0};
    vecs[9]  = '{5'b00000, 32'h1C000120, 32'h5000, 32'h1234,     1'b0, 5'd0, 1'b1, 16'h0,   2, 0, 32'hFFFFFFFF, 32'h1234,     2};
    vecs[10] = '{5'b10000, 32'h1C000124, 32'h6000, 32'h6000,     1'b1, 5'd2, 1'b1, 16'h0,   0, 2, 32'h00000011, 32'h00000011, 2};
    vecs[11] = '{5'b00000, 32'h1C000128, 32'h0,    32'hDEADBEEF, 1'b1, 5'd1, 1'b0, 16'h0,   0, 2, 32'h0,        32'hDEADBEEF, 2};

    // Reset state
    #2;
    chk("rst.allowin", ms_allowin, 1);
    chk("rst.to_ws_valid", ms_to_ws_valid, 0);
    chk("rst.rf_collect", ms_rf_collect, 0);
    chk("rst.fwd", ms_fwd, 0);
    chk("rst.stall_ex", {ms_load_stall, ms_ex}, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Flush while a load waits: its response must be swallowed.
    capture_load(32'h100);
    @(posedge clk); #1;
    wb_flush = 1'b1;
    #1 chk("flush1.no_handoff", ms_to_ws_valid, 0);
    @(posedge clk); #1;
    wb_flush = 1'b0;
    chk("flush1.invalid", ms_allowin, 1);
    chk("flush1.drop_cnt", dut.drop_cnt_q, 1);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD;
    #1 chk("flush1.stale_ignored", ms_to_ws_valid, 0);
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
    chk("flush1.drop_done", dut.drop_cnt_q, 0);
    begin
      vec_t v;
      v = '{5'b10000, 32'h1C000200, 32'h7000, 32'h7000, 1'b1, 5'd2, 1'b1, 16'h0, 1, 0,
            32'h11, 32'h11, 1};
      run_vec(v, "after_flush");
    end

    // Flush while EX issues a request too: two responses to swallow.
    capture_load(32'h200);
    wb_flush = 1'b1; es_to_ms_valid = 1'b1; es_mem_req = 1'b1; es_mem_op = 5'b10000;
    @(posedge clk); #1;
    wb_flush = 1'b0; es_to_ms_valid = 1'b0; es_mem_req = 1'b0;
    chk("flush2.invalid", ms_allowin, 1);
    chk("flush2.drop_cnt", dut.drop_cnt_q, 2);
    for (int k = 0; k < 2; k++) begin
      data_sram_data_ok = 1'b1; data_sram_rdata = $urandom;
      #1 chk($sformatf("flush2.stale%0d", k), ms_to_ws_valid, 0);
      @(posedge clk); #1;
    end
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
    chk("flush2.drop_done", dut.drop_cnt_q, 0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 150; n++) begin
      vec_t v;
      int k;
      k = $urandom_range(0, 6);
      v.op    = (k < 5) ? 5'(1 << k) : 5'b0;
      v.pc    = $urandom;
      v.vaddr = $urandom;
      if (k == LD_H || k == LD_HU) v.vaddr[0] = 1'b0;
      if (k == LD_W) v.vaddr[1:0] = 2'b00;
      v.alu   = $urandom;
      v.we    = (k != 6);
      v.waddr = 5'($urandom);
      v.req   = (k != 5);
      v.exc   = ($urandom_range(0, 7) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'h0;
      v.delay = $urandom_range(0, 4);
      v.allow = $urandom_range(0, 4);
      v.rdata = $urandom;
      v.exp_wdata = ref_wdata(v);
      v.exp_lat   = ref_lat(v);
      run_vec(v, $sformatf("rnd%0d", n));
    end

    // Reset in the middle of a wait, with a stale response pending.
    capture_load(32'h300);
    wb_flush = 1'b1;
    @(posedge clk); #1;
    wb_flush = 1'b0;
    chk("rst2.drop_pre", dut.drop_cnt_q, 1);
    capture_load(32'h304);
    #2 reset = 1'b1;
    #1;
    chk("rst2.allowin", ms_allowin, 1);
    chk("rst2.to_ws_valid", ms_to_ws_valid, 0);
    chk("rst2.rf_collect", ms_rf_collect, 0);
    chk("rst2.pc_vaddr", {ms_pc, vaddr}, 0);
    chk("rst2.stall", ms_load_stall, 0);
    chk("rst2.fwd", ms_fwd, 0);
    chk("rst2.drop_cnt", dut.drop_cnt_q, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

endmodule
